ex_branch_resolve_stage: RTL and testbench

- Consumer end of the 64-bit ALU's output interface (Result, zero, lt).
- Resolves branches and jumps from the ALU flags and registers the execute-stage result into the EX/MEM pipeline register, with a valid/ready handshake toward MEM.
- Issues a one-cycle redirect to the fetch frontend on a taken branch and squashes wrong-path shadow instructions.
- Keeps saturating branch and taken-branch performance counters.

---
 rtl/rv_ex_pkg.sv | 17 +
 rtl/branch_cond_eval.sv | 18 +
 rtl/ex_branch_resolve_stage.sv | 94 +++++++++
 tb/tb_ex_branch_resolve_stage.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/rv_ex_pkg.sv
// rv_ex_pkg: shared execute-stage types and widths
package rv_ex_pkg;
  localparam int XLEN = 64;
  localparam int REG_ADDR_W = 5;
  typedef enum logic [2:0] {
    BR_NONE = 3'd0,
    BR_BEQ  = 3'd1,
    BR_BNE  = 3'd2,
    BR_BLT  = 3'd3,
    BR_BGE  = 3'd4,
    BR_JAL  = 3'd5,
    BR_JALR = 3'd6
  } br_type_t;
  function automatic logic is_link(input br_type_t t);
    return t == BR_JAL || t == BR_JALR;
  endfunction
endpackage

// File: rtl/branch_cond_eval.sv
// branch_cond_eval: branch taken decision from ALU flags
module branch_cond_eval
  import rv_ex_pkg::*;
(
  input  br_type_t br_type,
  input  logic     zero,
  input  logic     lt,
  output logic     taken,
  output logic     is_branch
);
  always_comb begin
    is_branch = br_type inside {BR_BEQ, BR_BNE, BR_BLT, BR_BGE, BR_JAL, BR_JALR};
    taken = br_type == BR_BEQ ? zero :
            br_type == BR_BNE ? ~zero :
            br_type == BR_BLT ? lt :
            br_type == BR_BGE ? ~lt : is_link(br_type);
  end
endmodule

// File: rtl/ex_branch_resolve_stage.sv
// ex_branch_resolve_stage: resolves branches, redirects fetch, squashes shadow
// instructions and registers the EX/MEM pipeline stage.
module ex_branch_resolve_stage
  import rv_ex_pkg::*;
#(
  parameter int SHADOW = 1,
  parameter int CNT_W = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [XLEN-1:0]       in_pc,
  input  logic [XLEN-1:0]       in_imm,
  input  logic [2:0]            in_br_type,
  input  logic [REG_ADDR_W-1:0] in_rd,
  input  logic                  in_reg_write,
  input  logic                  in_mem_read,
  input  logic                  in_mem_write,
  input  logic [XLEN-1:0]       in_store_data,
  input  logic [XLEN-1:0]       alu_result,
  input  logic                  alu_zero,
  input  logic                  alu_lt,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [XLEN-1:0]       out_result,
  output logic [XLEN-1:0]       out_store_data,
  output logic [REG_ADDR_W-1:0] out_rd,
  output logic                  out_reg_write,
  output logic                  out_mem_read,
  output logic                  out_mem_write,
  output logic                  redirect_valid,
  output logic [XLEN-1:0]       redirect_pc,
  output logic [CNT_W-1:0]      perf_branches,
  output logic [CNT_W-1:0]      perf_taken
);
  localparam logic [1:0] SH = SHADOW[1:0];
  br_type_t br;
  logic taken, is_branch, accept, squash, take_in, redir;
  logic [1:0] sq_cnt;
  logic [XLEN-1:0] target, result;
  assign br = br_type_t'(in_br_type);
  branch_cond_eval u_cond (
    .br_type(br),
    .zero(alu_zero),
    .lt(alu_lt),
    .taken(taken),
    .is_branch(is_branch)
  );
  always_comb begin
    in_ready = ~out_valid | out_ready;
    accept = in_valid & in_ready;
    squash = accept & (sq_cnt != 2'd0);
    take_in = accept & ~squash;
    redir = take_in & taken;
    target = br == BR_JALR ? {alu_result[XLEN-1:1], 1'b0} : in_pc + in_imm;
    result = is_link(br) ? in_pc + XLEN'(4) : alu_result;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_result <= '0;
      out_store_data <= '0;
      out_rd <= '0;
      out_reg_write <= 1'b0;
      out_mem_read <= 1'b0;
      out_mem_write <= 1'b0;
      redirect_valid <= 1'b0;
      redirect_pc <= '0;
      perf_branches <= '0;
      perf_taken <= '0;
      sq_cnt <= '0;
    end else begin
      redirect_valid <= redir;
      if (redir) redirect_pc <= target;
      if (take_in) begin
        out_valid <= 1'b1;
        out_result <= result;
        out_store_data <= in_store_data;
        out_rd <= in_rd;
        out_reg_write <= in_reg_write;
        out_mem_read <= in_mem_read;
        out_mem_write <= in_mem_write;
      end else if (in_ready) begin
        out_valid <= 1'b0;
      end
      // a squashed accept still consumes one shadow slot
      if (redir) sq_cnt <= SH;
      else if (squash) sq_cnt <= sq_cnt - 2'd1;
      if (take_in && is_branch && !(&perf_branches)) perf_branches <= perf_branches + CNT_W'(1);
      if (redir && !(&perf_taken)) perf_taken <= perf_taken + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_ex_branch_resolve_stage.sv
// tb_ex_branch_resolve_stage: scoreboard bench for the branch resolve stage
module tb_ex_branch_resolve_stage;
  localparam int CNT_W = 4;
  logic clk = 1'b0, reset = 1'b1;
  logic in_valid = 1'b0, in_ready;
  logic [63:0] in_pc = '0, in_imm = '0, in_store_data = '0, alu_result = '0;
  logic [2:0] in_br_type = '0;
  logic [4:0] in_rd = '0;
  logic in_reg_write = 1'b0, in_mem_read = 1'b0, in_mem_write = 1'b0;
  logic alu_zero = 1'b0, alu_lt = 1'b0;
  logic out_valid, out_ready = 1'b1;
  logic [63:0] out_result, out_store_data, redirect_pc;
  logic [4:0] out_rd;
  logic out_reg_write, out_mem_read, out_mem_write, redirect_valid;
  logic [CNT_W-1:0] perf_branches, perf_taken;
  int n_cmp = 0, n_bad = 0;

  typedef struct {
    logic [63:0] result;
    logic [63:0] sd;
    logic [4:0]  rd;
    logic        rw, mr, mw;
  } exp_t;
  exp_t q[$];
  logic m_valid = 1'b0;
  int m_sq = 0, m_br = 0, m_tk = 0;
  logic [63:0] m_rpc = '0;

  ex_branch_resolve_stage #(.SHADOW(1), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_imm(in_imm), .in_br_type(in_br_type), .in_rd(in_rd),
    .in_reg_write(in_reg_write), .in_mem_read(in_mem_read), .in_mem_write(in_mem_write),
    .in_store_data(in_store_data), .alu_result(alu_result), .alu_zero(alu_zero),
    .alu_lt(alu_lt), .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_store_data(out_store_data), .out_rd(out_rd),
    .out_reg_write(out_reg_write), .out_mem_read(out_mem_read),
    .out_mem_write(out_mem_write), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .perf_branches(perf_branches), .perf_taken(perf_taken)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic m_taken(input logic [2:0] t, input logic z, input logic l);
    case (t)
      3'd1: return z;
      3'd2: return !z;
      3'd3: return l;
      3'd4: return !l;
      3'd5, 3'd6: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic ins(input logic [2:0] bt, input logic [63:0] pc, input logic [63:0] imm,
                     input logic [63:0] res, input logic z, input logic l, input logic [4:0] rd);
    in_valid = 1'b1; in_br_type = bt; in_pc = pc; in_imm = imm; alu_result = res;
    alu_zero = z; alu_lt = l; in_rd = rd;
    in_reg_write = rd != 0; in_mem_read = rd[0]; in_mem_write = rd[1];
    in_store_data = {pc[31:0], res[31:0]} ^ 64'hA5A5;
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  // one clock: check pre-edge outputs, advance model, check post-edge outputs
  task automatic cyc(input logic ordy);
    logic acc, tin, redir;
    logic [63:0] tgt;
    exp_t e;
    out_ready = ordy;
    #1;
    chk("in_ready", in_ready, !m_valid || ordy);
    chk("out_valid", out_valid, m_valid);
    if (m_valid) begin
      if (q.size() == 0) chk("queue_empty", 0, 1);
      else begin
        e = q[0];
        chk("out_result", out_result, e.result);
        chk("out_store_data", out_store_data, e.sd);
        chk("out_rd", out_rd, e.rd);
        chk("out_ctl", {out_reg_write, out_mem_read, out_mem_write}, {e.rw, e.mr, e.mw});
        if (ordy) void'(q.pop_front());
      end
    end
    acc = in_valid && (!m_valid || ordy);
    tin = acc && m_sq == 0;
    redir = tin && m_taken(in_br_type, alu_zero, alu_lt);
    tgt = in_br_type == 3'd6 ? {alu_result[63:1], 1'b0} : in_pc + in_imm;
    if (tin) begin
      e.result = (in_br_type == 3'd5 || in_br_type == 3'd6) ? in_pc + 64'd4 : alu_result;
      e.sd = in_store_data; e.rd = in_rd;
      e.rw = in_reg_write; e.mr = in_mem_read; e.mw = in_mem_write;
      q.push_back(e);
    end
    m_valid = tin ? 1'b1 : (!m_valid || ordy) ? 1'b0 : m_valid;
    if (redir) m_sq = 1; else if (acc && m_sq > 0) m_sq--;
    if (tin && in_br_type >= 3'd1 && in_br_type <= 3'd6 && m_br < 15) m_br++;
    if (redir && m_tk < 15) m_tk++;
    if (redir) m_rpc = tgt;
    @(posedge clk);
    #1;
    chk("redirect_valid", redirect_valid, redir);
    chk("redirect_pc", redirect_pc, m_rpc);
    chk("perf_branches", perf_branches, 64'(m_br));
    chk("perf_taken", perf_taken, 64'(m_tk));
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_redirect", redirect_valid, 0);
    chk("rst_result", out_result, 0);
    chk("rst_perf", {perf_branches, perf_taken}, 0);
    reset = 1'b0;
    #1;
    chk("rst_in_ready", in_ready, 1);
    // taken BEQ then a squashed shadow op
    ins(3'd1, 64'h1000, 64'h40, 64'h0, 1'b1, 1'b0, 5'd0); cyc(1'b1);
    chk("beq_redirect_pc", redirect_pc, 64'h1040);
    ins(3'd0, 64'h1004, 0, 64'h55, 1'b0, 1'b0, 5'd3); cyc(1'b1);
    chk("beq_shadow_squashed", out_valid, 0);
    ins(3'd0, 64'h1040, 0, 64'h66, 1'b0, 1'b0, 5'd4); cyc(1'b1);
    // not-taken BNE, following op not squashed
    ins(3'd2, 64'h1044, 64'h80, 64'h1234, 1'b1, 1'b0, 5'd5); cyc(1'b1);
    ins(3'd0, 64'h1048, 0, 64'h77, 1'b0, 1'b0, 5'd6); cyc(1'b1);
    chk("bne_next_valid", out_valid, 1);
    // JALR: target bit0 cleared, link = pc+4
    ins(3'd6, 64'h2000, 64'h0, 64'h3001, 1'b0, 1'b0, 5'd1); cyc(1'b1);
    chk("jalr_target", redirect_pc, 64'h3000);
    chk("jalr_link", out_result, 64'h2004);
    ins(3'd0, 64'h2004, 0, 64'h88, 1'b0, 1'b0, 5'd2); cyc(1'b1);
    // stall for 3 cycles then back-to-back resume
    ins(3'd0, 64'h3000, 0, 64'h99, 1'b0, 1'b0, 5'd7); cyc(1'b1);
    ins(3'd0, 64'h3004, 0, 64'hAA, 1'b0, 1'b0, 5'd8);
    repeat (3) cyc(1'b0);
    cyc(1'b1);
    ins(3'd0, 64'h3008, 0, 64'hBB, 1'b0, 1'b0, 5'd9); cyc(1'b1);
    // taken BLT with a taken BGE in its shadow
    ins(3'd3, 64'h4000, 64'h100, 64'h1, 1'b0, 1'b1, 5'd0); cyc(1'b1);
    ins(3'd4, 64'h4004, 64'h200, 64'h0, 1'b0, 1'b0, 5'd0); cyc(1'b1);
    chk("bge_shadow_no_redirect", redirect_valid, 0);
    idle(); cyc(1'b1);
    // reserved code acts as plain op; JAL wraps
    ins(3'd7, 64'h5000, 64'h10, 64'hCC, 1'b1, 1'b1, 5'd10); cyc(1'b1);
    ins(3'd5, 64'hFFFF_FFFF_FFFF_FFFE, 64'h10, 64'h0, 1'b0, 1'b0, 5'd11); cyc(1'b1);
    chk("jal_wrap_link", out_result, 64'h2);
    chk("jal_wrap_target", redirect_pc, 64'hE);
    ins(3'd0, 64'h0, 0, 64'hDD, 1'b0, 1'b0, 5'd12); cyc(1'b1);
    // saturate both counters
    for (int i = 0; i < 16; i++) begin
      ins(3'd5, 64'h6000 + 64'(i * 8), 64'h20, 64'h0, 1'b0, 1'b0, 5'd13); cyc(1'b1);
      ins(3'd0, 64'h6004, 0, 64'h1, 1'b0, 1'b0, 5'd14); cyc(1'b1);
    end
    chk("sat_branches", perf_branches, 64'hF);
    chk("sat_taken", perf_taken, 64'hF);
    idle(); cyc(1'b1);
    // reset mid-stall with a pending redirect
    ins(3'd5, 64'h7000, 64'h40, 64'h0, 1'b0, 1'b0, 5'd15); cyc(1'b1);
    out_ready = 1'b0; reset = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_redirect", redirect_valid, 0);
    chk("mid_rst_fields", {out_result, out_rd, out_reg_write}, 0);
    chk("mid_rst_perf", {perf_branches, perf_taken}, 0);
    chk("mid_rst_rpc", redirect_pc, 0);
    reset = 1'b0;
    q.delete(); m_valid = 0; m_sq = 0; m_br = 0; m_tk = 0; m_rpc = '0;
    ins(3'd0, 64'h7004, 0, 64'hEE, 1'b0, 1'b0, 5'd16); cyc(1'b1);
    chk("post_rst_not_squashed", out_valid, 1);
    idle(); cyc(1'b1); cyc(1'b1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
